// File: rtl/range_list_decoder.sv
// range_list_decoder: byte-stream parser for the two-section puzzle input.
// Section one carries "lo-hi" range lines and yields range pairs; a blank
// line switches to section two, whose single-number lines yield ID records;
// a second blank line marks end of file. CR bytes are dropped everywhere.
//
// Optional feature macro: RANGE_DECODER_OVERFLOW_CHECK_EN
//   defined   : a digit that overflows VALUE_WIDTH sets overflow + parse_error
//               and the overflowing record is dropped.
//   undefined : accumulation wraps silently, overflow is tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   inbound_valid/byte     one ASCII byte per asserted cycle, no backpressure
//   section                0 = ranges, 1 = IDs
//   range_valid/lo/hi      one-cycle pulse qualifying a held range pair
//   id_valid/id_data       one-cycle pulse qualifying a held ID
//   range_count/id_count   records emitted so far (wrapping)
//   end_of_file            sticky, second blank line seen
//   parse_error            sticky, malformed input (or overflow) seen
//   overflow               sticky, accumulation overflow seen
module range_list_decoder #(
   parameter int unsigned VALUE_WIDTH = 64,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inbound_valid,
   input  logic [7:0]             inbound_byte,
   output logic                   section,
   output logic                   range_valid,
   output logic [VALUE_WIDTH-1:0] range_lo,
   output logic [VALUE_WIDTH-1:0] range_hi,
   output logic                   id_valid,
   output logic [VALUE_WIDTH-1:0] id_data,
   output logic [COUNT_WIDTH-1:0] range_count,
   output logic [COUNT_WIDTH-1:0] id_count,
   output logic                   end_of_file,
   output logic                   parse_error,
   output logic                   overflow
);

   localparam int unsigned EXT_WIDTH = VALUE_WIDTH + 4;

   typedef enum logic [2:0] {
      LINE_START,
      LO_DIGITS,
      HI_START,
      HI_DIGITS,
      ID_LINE_START,
      ID_DIGITS,
      DONE,
      ERROR
   } state_t;

   state_t                 state_q, state_d;
   logic [VALUE_WIDTH-1:0] acc_q, acc_d;
   logic [VALUE_WIDTH-1:0] lo_q, lo_d;

   logic                   section_d, range_valid_d, id_valid_d;
   logic [VALUE_WIDTH-1:0] range_lo_d, range_hi_d, id_data_d;
   logic [COUNT_WIDTH-1:0] range_count_d, id_count_d;
   logic                   end_of_file_d, parse_error_d;

   // Byte classification
   logic                   is_digit, is_dash, is_lf, is_cr;
   logic [VALUE_WIDTH-1:0] digit_val;
   logic [VALUE_WIDTH-1:0] acc_mac;
   logic                   accum_ok;

   assign is_digit  = (inbound_byte >= 8'h30) && (inbound_byte <= 8'h39);
   assign is_dash   = (inbound_byte == 8'h2D);
   assign is_lf     = (inbound_byte == 8'h0A);
   assign is_cr     = (inbound_byte == 8'h0D);
   assign digit_val = VALUE_WIDTH'(inbound_byte[3:0]);

`ifdef RANGE_DECODER_OVERFLOW_CHECK_EN
   // Widened multiply-accumulate; any bit above VALUE_WIDTH means overflow
   logic [EXT_WIDTH-1:0] acc_ext;
   logic                 overflow_d;

   assign acc_ext  = EXT_WIDTH'(acc_q) * EXT_WIDTH'(10) + EXT_WIDTH'(inbound_byte[3:0]);
   assign acc_mac  = acc_ext[VALUE_WIDTH-1:0];
   assign accum_ok = ~(|acc_ext[EXT_WIDTH-1:VALUE_WIDTH]);
`else
   // Truncated result of the widened sum equals the modulo-2^W product-sum
   assign acc_mac  = acc_q * VALUE_WIDTH'(10) + digit_val;
   assign accum_ok = 1'b1;
   assign overflow = 1'b0;
`endif

   // Next-state, datapath and output logic
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      lo_d          = lo_q;
      section_d     = section;
      range_valid_d = 1'b0;
      range_lo_d    = range_lo;
      range_hi_d    = range_hi;
      id_valid_d    = 1'b0;
      id_data_d     = id_data;
      range_count_d = range_count;
      id_count_d    = id_count;
      end_of_file_d = end_of_file;

      if (inbound_valid && !is_cr) begin
         case (state_q)
            LINE_START: begin
               if (is_digit) begin
                  acc_d   = digit_val;
                  state_d = LO_DIGITS;
               end else if (is_lf) begin
                  section_d = 1'b1;
                  state_d   = ID_LINE_START;
               end else begin
                  state_d = ERROR;
               end
            end
            LO_DIGITS: begin
               if (is_digit) begin
                  if (accum_ok) acc_d = acc_mac;
                  else          state_d = ERROR;
               end else if (is_dash) begin
                  lo_d    = acc_q;
                  state_d = HI_START;
               end else begin
                  state_d = ERROR;
               end
            end
            HI_START: begin
               if (is_digit) begin
                  acc_d   = digit_val;
                  state_d = HI_DIGITS;
               end else begin
                  state_d = ERROR;
               end
            end
            HI_DIGITS: begin
               if (is_digit) begin
                  if (accum_ok) acc_d = acc_mac;
                  else          state_d = ERROR;
               end else if (is_lf) begin
                  range_valid_d = 1'b1;
                  range_lo_d    = lo_q;
                  range_hi_d    = acc_q;
                  range_count_d = range_count + COUNT_WIDTH'(1);
                  state_d       = LINE_START;
               end else begin
                  state_d = ERROR;
               end
            end
            ID_LINE_START: begin
               if (is_digit) begin
                  acc_d   = digit_val;
                  state_d = ID_DIGITS;
               end else if (is_lf) begin
                  end_of_file_d = 1'b1;
                  state_d       = DONE;
               end else begin
                  state_d = ERROR;
               end
            end
            ID_DIGITS: begin
               if (is_digit) begin
                  if (accum_ok) acc_d = acc_mac;
                  else          state_d = ERROR;
               end else if (is_lf) begin
                  id_valid_d = 1'b1;
                  id_data_d  = acc_q;
                  id_count_d = id_count + COUNT_WIDTH'(1);
                  state_d    = ID_LINE_START;
               end else begin
                  state_d = ERROR;
               end
            end
            default: ; // DONE and ERROR absorb every byte
         endcase
      end

      parse_error_d = parse_error | (state_d == ERROR);

`ifdef RANGE_DECODER_OVERFLOW_CHECK_EN
      overflow_d = overflow |
                   (inbound_valid && is_digit && !accum_ok &&
                    ((state_q == LO_DIGITS) || (state_q == HI_DIGITS) ||
                     (state_q == ID_DIGITS)));
`endif
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LINE_START;
         acc_q       <= '0;
         lo_q        <= '0;
         section     <= 1'b0;
         range_valid <= 1'b0;
         range_lo    <= '0;
         range_hi    <= '0;
         id_valid    <= 1'b0;
         id_data     <= '0;
         range_count <= '0;
         id_count    <= '0;
         end_of_file <= 1'b0;
         parse_error <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         section     <= section_d;
         range_valid <= range_valid_d;
         range_lo    <= range_lo_d;
         range_hi    <= range_hi_d;
         id_valid    <= id_valid_d;
         id_data     <= id_data_d;
         range_count <= range_count_d;
         id_count    <= id_count_d;
         end_of_file <= end_of_file_d;
         parse_error <= parse_error_d;
      end
   end

`ifdef RANGE_DECODER_OVERFLOW_CHECK_EN
   // Sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else        overflow <= overflow_d;
   end
`endif

endmodule
